// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid port, redirect/halt control and the ir/pc handshake to decode.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        ir_ready;

    modport master (
        output imem_req, imem_addr, ir, pc, ir_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir, pc, ir_valid,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, in-order prefetch FIFO, ir/pc valid on the cycle after push.
// Stops issuing while the FIFO plus the outstanding read would overflow; redirect flushes, halt is sticky.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH, S_HALTED} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [31:0]        last_pc_q;
    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]     count_q, count_d;

    logic req_d, issue, push, pop, clear, fifo_empty;

    assign fifo_empty    = (count_q == '0);
    assign bus.ir_valid  = !fifo_empty;
    assign bus.ir        = fifo_empty ? NOP : mem_q[rd_ptr_q].ir;
    assign bus.pc        = fifo_empty ? last_pc_q : mem_q[rd_ptr_q].pc;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.imem_req  = req_d;
    assign pop           = bus.ir_valid && bus.ir_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_d      = 1'b0;
        issue      = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;

        case (state_q)
            S_RUN: begin
                // RUN has nothing outstanding, so count<DEPTH guarantees the response fits.
                req_d = rst_n && (count_q < DEPTH_C) && !bus.halt;
                issue = req_d && bus.imem_gnt;
                if (issue) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (bus.imem_rvalid) begin
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase

        if (state_q != S_HALTED) begin
            if (bus.halt) begin
                push    = 1'b0;
                clear   = 1'b1;
                state_d = S_HALTED;
            end else if (bus.redirect) begin
                push       = 1'b0;
                clear      = 1'b1;
                fetch_pc_d = bus.redirect_pc & ~32'd3;
                // A read still in flight after this edge must be swallowed before issuing again.
                if (issue || ((state_q inside {S_WAIT, S_FLUSH}) && !bus.imem_rvalid)) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            // pc keeps showing the most recent head once the FIFO drains.
            if (!fifo_empty) begin
                last_pc_q <= mem_q[rd_ptr_q].pc;
            end
            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: req_pc_q, ir: bus.imem_rdata};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect (in WAIT and with same-cycle pop), halt.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic mem_auto;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: memory answers one cycle after an issue when mem_auto is set; pulses drop after the edge.
    task automatic cyc();
        logic        iss;
        logic [31:0] a;
        iss = bus.imem_req & bus.imem_gnt;
        a   = bus.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            bus.imem_rvalid = iss;
            bus.imem_rdata  = iss ? (a ^ 32'hA5A5_0000) : 32'h0;
        end
        bus.redirect = 1'b0;
        bus.halt     = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        bus.imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    // Pops n entries in order, checking pc and ir; last_cyc = cycles elapsed when the n-th was visible.
    task automatic collect(input int n, input logic [31:0] start, output int last_cyc);
        int          got;
        int          c;
        logic [31:0] exp;
        got      = 0;
        c        = 0;
        exp      = start;
        last_cyc = -1;
        while (got < n && c < 60) begin
            if (bus.ir_valid && bus.ir_ready) begin
                chk("pop_pc", bus.pc, exp);
                chk("pop_ir", bus.ir, exp ^ 32'hA5A5_0000);
                exp      = exp + 32'd4;
                got      = got + 1;
                last_cyc = c;
            end
            cyc();
            c = c + 1;
        end
        chk("pop_count", got, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lc;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt        = 1'b0;
        bus.ir_ready    = 1'b1;
        mem_auto        = 1'b1;

        // Reset values
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_vld", bus.ir_valid, 1'b0);
        chk("rst_ir", bus.ir, 32'h0000_0013);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk1("first_req", bus.imem_req, 1'b1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // Streaming: one instruction every two cycles
        collect(6, 32'h0, lc);
        chk("stream_rate", lc, 12);
        cyc();
        chk1("pre_rst_vld", bus.ir_valid, 1'b1);
        chk("pre_rst_pc", bus.pc, 32'h18);

        // Mid-run reset takes effect without a clock
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_req", bus.imem_req, 1'b0);
        chk1("mid_rst_vld", bus.ir_valid, 1'b0);
        chk("mid_rst_ir", bus.ir, 32'h0000_0013);
        chk("mid_rst_pc", bus.pc, 32'h0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_addr", bus.imem_addr, 32'h0);

        // Backpressure: two pushes fill the FIFO, then issue stops
        bus.ir_ready = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < 6; i++) begin
            chk1("bp_req", bus.imem_req, 1'b0);
            chk("bp_ir", bus.ir, 32'hA5A5_0000);
            cyc();
        end
        bus.ir_ready = 1'b1;
        collect(3, 32'h0, lc);

        // Redirect while a read is outstanding
        do_reset();
        mem_auto     = 1'b0;
        bus.ir_ready = 1'b1;
        cyc();
        chk1("rw_wait_req", bus.imem_req, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        cyc();
        chk1("rw_flush_req", bus.imem_req, 1'b0);
        chk1("rw_vld", bus.ir_valid, 1'b0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        chk1("rw_drop_vld", bus.ir_valid, 1'b0);
        chk1("rw_req", bus.imem_req, 1'b1);
        chk("rw_addr", bus.imem_addr, 32'h0000_0100);
        mem_auto = 1'b1;
        collect(1, 32'h0000_0100, lc);
        chk("rw_lat", lc, 2);

        // Redirect with a same-cycle pop; target wraps past the top of memory
        do_reset();
        mem_auto     = 1'b1;
        bus.ir_ready = 1'b0;
        repeat (4) cyc();
        bus.ir_ready = 1'b1;
        cyc();
        cyc();
        bus.ir_ready = 1'b0;
        repeat (3) cyc();
        chk1("rp_vld", bus.ir_valid, 1'b1);
        chk("rp_pc", bus.pc, 32'h8);
        chk1("rp_full_req", bus.imem_req, 1'b0);
        bus.ir_ready    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        cyc();
        chk1("rp_after_vld", bus.ir_valid, 1'b0);
        chk1("rp_after_req", bus.imem_req, 1'b1);
        chk("rp_after_addr", bus.imem_addr, 32'hFFFF_FFFC);
        collect(2, 32'hFFFF_FFFC, lc);

        // Halt: blocks issue immediately, then sticks until reset
        do_reset();
        mem_auto     = 1'b0;
        bus.ir_ready = 1'b1;
        bus.halt     = 1'b1;
        #1;
        chk1("halt_gate_req", bus.imem_req, 1'b0);
        bus.halt = 1'b0;
        #1;
        cyc();
        bus.halt = 1'b1;
        cyc();
        chk1("halt_req", bus.imem_req, 1'b0);
        chk1("halt_vld", bus.ir_valid, 1'b0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        cyc();
        bus.imem_rvalid = 1'b0;
        #1;
        chk1("halt_rv_vld", bus.ir_valid, 1'b0);
        chk1("halt_rv_req", bus.imem_req, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        cyc();
        cyc();
        chk1("halt_rd_req", bus.imem_req, 1'b0);
        chk1("halt_rd_vld", bus.ir_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk1("halt_exit_req", bus.imem_req, 1'b1);
        chk("halt_exit_addr", bus.imem_addr, 32'h0);
        mem_auto = 1'b1;
        collect(1, 32'h0, lc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
